// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ----------------------------------------------------------------------------
// Shares one UART transmitter (tx_en / tx_din / tx_busy) between NUM_REQ
// byte producers. Requesters are served round-robin through a valid/ready
// handshake. Each accepted byte gets a one-cycle tx_en launch. The arbiter
// then waits for the transmitter to go busy and then idle again, and finally
// applies an optional inter-byte gap before it accepts the next byte.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   DATA_W      byte width
//   ACK_TIMEOUT max cycles to wait for tx_busy to rise after a launch
//   GAP_CYCLES  idle cycles forced after tx_busy falls
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous, active-high reset
//   req_valid    per-requester byte valid
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   req_last     (UART_ARB_LOCK_EN only) 0 keeps arbitration locked to the sender
//   req_ready    accept strobe, byte taken when valid & ready
//   grant        one-hot owner of the transmitter
//   tx_en        one-cycle launch strobe to the UART TX
//   tx_din       byte to transmit, holds until the next launch
//   tx_busy      transmitter busy
//   arb_busy     high whenever the FSM is not IDLE
//   err_timeout  one-cycle pulse when a launch is not acknowledged
//
// Optional feature macro: UART_ARB_LOCK_EN (requester lock via req_last).
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_din,
  input  logic                      tx_busy,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] eligible;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic               accept;
  logic               timeout_hit;

`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0] lock_mask;
`endif

  // Round-robin search starting one past the last winner. While a lock is
  // held only the locked requester is eligible. Acceptance is suppressed
  // during reset so req_ready reads 0 while sys_rst is high.
  always_comb begin
    eligible = req_valid;
`ifdef UART_ARB_LOCK_EN
    if (|lock_mask) eligible = req_valid & lock_mask;
`endif
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    accept      = (state == ST_IDLE) && !tx_busy && found && !sys_rst;
    req_ready   = accept ? (NUM_REQ'(1) << winner) : '0;
    timeout_hit = (state == ST_WAIT_START) && !tx_busy &&
                  (cnt == CNT_W'(ACK_TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic plus the purely state-decoded outputs.
  always_comb begin
    state_next  = state;
    tx_en       = (state == ST_LAUNCH);
    arb_busy    = (state != ST_IDLE);
    err_timeout = timeout_hit;
    case (state)
      ST_IDLE:       if (accept) state_next = ST_LAUNCH;
      ST_LAUNCH:     state_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (tx_busy)          state_next = ST_WAIT_DONE;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_WAIT_DONE:  if (!tx_busy) state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Datapath. The byte is latched on the accepting edge and driven on tx_din
  // until the next acceptance. The shared counter clears on every state
  // change, so it restarts at 0 on entry to WAIT_START and to GAP. Its exit
  // compares stop it before it can wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr <= PTR_W'(NUM_REQ - 1);
      grant  <= '0;
      tx_din <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= winner;
        grant  <= NUM_REQ'(1) << winner;
        tx_din <= req_data[winner*DATA_W +: DATA_W];
      end else if (state_next == ST_IDLE || state_next == ST_GAP) begin
        grant  <= '0;
      end
      if (state_next != state)
        cnt <= '0;
      else if (state == ST_WAIT_START || state == ST_GAP)
        cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef UART_ARB_LOCK_EN
  // Lock register. A byte accepted with req_last=0 pins arbitration to its
  // sender. A byte with req_last=1, a timeout or a reset releases the lock.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || timeout_hit)
      lock_mask <= '0;
    else if (accept)
      lock_mask <= req_last[winner] ? '0 : (NUM_REQ'(1) << winner);
  end
`endif

endmodule
